hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 6-stage core (IF, ID, EX, MEM1, MEM2, WB).
- Compares the instruction in ID, using decoded control bits from the main decoder, against a 2-entry scoreboard of in-flight writers in EX and MEM1.
- From that comparison it generates the stall, bubble and flush strobes for the pipeline registers.
- It also absorbs a memory-busy freeze from the data-memory side.
- It sits beside the ID stage and drives the PC, IF/ID and ID/EX register enables.

## Interface
Parameters:
- REG_AW, 5: register-address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  source register addresses.
- id_use_rs, id_use_rt  in  1  instruction reads rs / rt.
- id_dst  in  REG_AW  destination, already muxed by regdst.
- id_regwrite, id_memread, id_branch  in  1  decoder controls; id_branch marks a jump resolved in ID.
- mem_busy  in  1  data memory cannot accept a MEM1 access this cycle.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load zeros into ID/EX controls.
- flush  out  1  invalidate IF/ID on the next edge.
- freeze  out  1  hold every pipeline register (PC through MEM2/WB).
- state  out  2  FSM state, for debug.

## Operation
- Scoreboard entries sb_ex and sb_mem1 each hold {v, dst, load}.
- Scoreboard update on each edge, unless frozen:
  - sb_mem1 <= sb_ex.
  - sb_ex <= issue ? {id_regwrite, id_dst, id_memread} : 0.
  - issue = id_valid & ~stall & ~freeze.
- Hazard condition: id_valid & a matching entry with v=1, load=1, dst!=0, where the match is (id_use_rs & rs==dst) | (id_use_rt & rt==dst).
- Non-load writers never stall; they are covered by forwarding.
- Load latency in ID:
  - A load in EX gives exactly 2 stall cycles.
  - A load in MEM1 gives 1 stall cycle.
- Register 0 never creates a hazard.
- Priority, highest first: freeze > stall > flush.
- freeze = mem_busy. While frozen, stall, bubble and flush are 0 and the scoreboard holds.
- When not frozen:
  - stall = bubble = hazard.
  - flush = id_valid & id_branch & ~hazard. A jump waiting on a hazard is not taken until the hazard clears.
- FSM states: RUN=0, STALL=1, FREEZE=2.
- FSM next state, evaluated each edge:
  - mem_busy → FREEZE.
  - otherwise hazard → STALL.
  - otherwise → RUN.
- The state register is informational only. All strobes are combinational from current inputs and the scoreboard.

## Timing
- Reset: stall=bubble=flush=freeze=0, state=RUN, both scoreboard entries cleared. Outputs are held while rst_n=0.
- Reset mid-stall: pending loads are forgotten and the first cycle after release is RUN.
- Strobe latency: 0 cycles, combinational, with no loops. id_* and mem_busy must arrive before roughly half the cycle.
- Jump flush: a jump in ID at cycle N drives flush in cycle N. IF/ID holds a bubble at N+1, giving a 1-cycle penalty.
- Freeze during a load-use stall: the stall resumes after mem_busy drops with its remaining count unchanged.
- Back-to-back loads to different registers: no stall.
- A consumer of both loads sees the union of the two matches.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - Adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - Each counter increments once per cycle its strobe is asserted and freeze=0.
  - Counters saturate at 0xFFFF and reset to 0.
- Not defined: the ports and counters are absent, with no other difference.

## Structure
- Shared package core_pkg holds:
  - opcode constants (LW=6'b100011, SW=6'b101011, RTYPE=6'b000000, XORI=6'b001110, J=6'b000010);
  - FSM state enum hz_state_t;
  - scoreboard entry struct sb_entry_t.
- One natural sub-module, hazard_cmp: the combinational match of one scoreboard entry against rs/rt. It is instantiated twice.

## Test plan
- lw r5 issued, next instr sub uses rs=5 → stall=bubble=1 for exactly 2 cycles, then issue. Same sequence with rs=0 → no stall.
- lw r5, one independent instr, then a user of r5 → stall for exactly 1 cycle.
- xori writes r7, next instr uses r7 → no stall (non-load writer).
- j in ID with no hazard → flush=1 for 1 cycle. j whose rs matches a load in EX → 2 stall cycles, then flush.
- mem_busy raised for 3 cycles during the first stall cycle of a load-use stall → freeze=1 and stall=0 for 3 cycles, then the remaining stall cycle; state goes FREEZE→STALL→RUN.
- rst_n pulsed low during a stall → all outputs 0 immediately, state=RUN, and the prior load no longer causes a stall.
- With HAZ_PERF_CNT_EN: after scenarios 1 and 4, stall_cnt=4 and flush_cnt=2.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: definitions shared across the 6-stage core.
//   - opcode constants for the main decoder (LW, SW, RTYPE, XORI, J)
//   - hz_state_t : hazard controller FSM state (RUN/STALL/FREEZE)
//   - sb_entry_t : one in-flight writer tracked by the hazard scoreboard
//   - small opcode classification helpers
package core_pkg;

  localparam int SB_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_STALL  = 2'd1,
    HZ_FREEZE = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic             v;
    logic [SB_AW-1:0] dst;
    logic             load;
  } sb_entry_t;

  function automatic logic op_is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic op_is_jump(input logic [5:0] op);
    return op == OP_J;
  endfunction

  function automatic logic op_writes_rt(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_XORI);
  endfunction

  function automatic logic op_is_rtype(input logic [5:0] op);
    return op == OP_RTYPE;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: combinational match of one scoreboard entry against the
// source registers of the instruction in ID. Only a valid load writing a
// non-zero register can match; other writers are covered by forwarding.
// Ports:
//   rs, rt          source register addresses of the ID instruction
//   use_rs, use_rt  the ID instruction actually reads rs / rt
//   entry           scoreboard entry {v, dst, load}
//   match           1 when the ID instruction depends on this load
module hazard_cmp
  import core_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  sb_entry_t         entry,
  output logic              match
);

  logic live_load;

  assign live_load = entry.v & entry.load & (entry.dst != '0);
  assign match     = live_load & ((use_rs & (rs == entry.dst)) |
                                  (use_rt & (rt == entry.dst)));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller beside the ID stage.
// Tracks loads in EX and MEM1 with a 2-entry scoreboard, raises
// stall/bubble on a load-use dependency, flush for a jump resolved in ID,
// and freeze while data memory is busy (freeze > stall > flush).
// All strobes are combinational; the state register is debug only.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs, id_rt               source registers
//   id_use_rs, id_use_rt       instruction reads rs / rt
//   id_dst                     destination register (after regdst mux)
//   id_regwrite, id_memread    decoder controls
//   id_branch                  jump resolved in ID
//   mem_busy                   data memory cannot accept a MEM1 access
//   stall, bubble, flush       PC/IF-ID hold, ID/EX zero, IF/ID invalidate
//   freeze                     hold all pipeline registers
//   state                      FSM state (RUN/STALL/FREEZE)
// Optional build macro HAZ_PERF_CNT_EN adds saturating 16-bit counters
//   stall_cnt and flush_cnt.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_branch,
  input  logic              mem_busy,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic              freeze,
  output logic [1:0]        state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  sb_entry_t sb_ex, sb_mem1, issue_entry;
  hz_state_t state_q, state_d;
  logic      match_ex, match_mem1, hazard, issue;

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp_ex (
    .rs(id_rs), .rt(id_rt), .use_rs(id_use_rs), .use_rt(id_use_rt),
    .entry(sb_ex), .match(match_ex)
  );

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp_mem1 (
    .rs(id_rs), .rt(id_rt), .use_rs(id_use_rs), .use_rt(id_use_rt),
    .entry(sb_mem1), .match(match_mem1)
  );

  // Strobes are gated by rst_n so they stay low throughout reset,
  // independent of whatever the ID stage presents.
  assign hazard = id_valid & (match_ex | match_mem1);
  assign freeze = rst_n & mem_busy;
  assign stall  = rst_n & ~mem_busy & hazard;
  assign bubble = stall;
  // A jump that depends on a pending load waits until the load clears.
  assign flush  = rst_n & ~mem_busy & id_valid & id_branch & ~hazard;
  assign issue  = id_valid & ~stall & ~freeze;

  always_comb begin
    issue_entry = '0;
    if (issue) begin
      issue_entry.v    = id_regwrite;
      issue_entry.dst  = id_dst;
      issue_entry.load = id_memread;
    end
  end

  // EX -> MEM1 scoreboard shift; holds while frozen so a pending stall
  // resumes with its remaining count intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_ex   <= '0;
      sb_mem1 <= '0;
    end else if (!freeze) begin
      sb_mem1 <= sb_ex;
      sb_ex   <= issue_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HZ_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = HZ_RUN;
    if (mem_busy)    state_d = HZ_FREEZE;
    else if (hazard) state_d = HZ_STALL;
  end

  assign state = state_q;

`ifdef HAZ_PERF_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall & ~freeze) stall_cnt <= sat_inc16(stall_cnt);
      if (flush & ~freeze) flush_cnt <= sat_inc16(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: inputs change 1 ns after the rising
// edge, combinational strobes and the state register are sampled on the
// falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs, id_use_rt;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_regwrite, id_memread, id_branch, mem_busy;
  logic       stall, bubble, flush, freeze;
  logic [1:0] state;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_branch(id_branch), .mem_busy(mem_busy),
    .stall(stall), .bubble(bubble), .flush(flush), .freeze(freeze),
    .state(state)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge: stall/bubble, flush, freeze, state.
  task automatic expect_out(input string tag, input int stl, input int fl,
                            input int fr, input int st);
    @(negedge clk);
    chk({tag, ".stall"},  int'(stall),  stl);
    chk({tag, ".bubble"}, int'(bubble), stl);
    chk({tag, ".flush"},  int'(flush),  fl);
    chk({tag, ".freeze"}, int'(freeze), fr);
    chk({tag, ".state"},  int'(state),  st);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int rs, input int rt,
                       input logic urs, input logic urt, input int dst,
                       input logic rw, input logic mr, input logic br);
    id_valid    = v;
    id_rs       = rs[4:0];
    id_rt       = rt[4:0];
    id_use_rs   = urs;
    id_use_rt   = urt;
    id_dst      = dst[4:0];
    id_regwrite = rw;
    id_memread  = mr;
    id_branch   = br;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // lw rX: base r1, destination rX
  task automatic lw(input int dst);
    drive(1'b1, 1, dst, 1'b1, 1'b0, dst, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset with noisy inputs: every strobe must stay low.
    rst_n    = 1'b0;
    mem_busy = 1'b1;
    drive(1'b1, 5, 6, 1'b1, 1'b1, 7, 1'b1, 1'b1, 1'b1);
    expect_out("reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    mem_busy = 1'b0;
    idle();
    rst_n = 1'b1;
    expect_out("post_reset", 0, 0, 0, 0);
    next_cycle();

    // lw r5 then sub using rs=5: 2 stall cycles, then issue.
    lw(5);
    expect_out("s1.lw", 0, 0, 0, 0);
    next_cycle();
    drive(1'b1, 5, 6, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0);
    expect_out("s1.stall1", 1, 0, 0, 0);
    next_cycle();
    expect_out("s1.stall2", 1, 0, 0, 1);
    next_cycle();
    expect_out("s1.issue", 0, 0, 0, 1);
    next_cycle();
    idle();
    expect_out("s1.idle", 0, 0, 0, 0);
    next_cycle();

    // Same with register 0: never a hazard.
    lw(0);
    expect_out("s1b.lw0", 0, 0, 0, 0);
    next_cycle();
    drive(1'b1, 0, 6, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0);
    expect_out("s1b.use0", 0, 0, 0, 0);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();

    // Jump with no hazard: 1-cycle flush.
    drive(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    expect_out("s4.j", 0, 1, 0, 0);
    next_cycle();
    idle();
    expect_out("s4.j_after", 0, 0, 0, 0);
    next_cycle();
    // Jump reading a load in EX: 2 stalls, then flush.
    lw(5);
    expect_out("s4.lw", 0, 0, 0, 0);
    next_cycle();
    drive(1'b1, 5, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    expect_out("s4.jstall1", 1, 0, 0, 0);
    next_cycle();
    expect_out("s4.jstall2", 1, 0, 0, 1);
    next_cycle();
    expect_out("s4.jflush", 0, 1, 0, 1);
    next_cycle();
    idle();
    expect_out("s4.idle", 0, 0, 0, 0);
`ifdef HAZ_PERF_CNT_EN
    chk("perf.stall_cnt", int'(stall_cnt), 4);
    chk("perf.flush_cnt", int'(flush_cnt), 2);
`endif
    next_cycle();
    next_cycle();

    // lw r5, independent instr, then user of r5: 1 stall cycle.
    lw(5);
    next_cycle();
    drive(1'b1, 1, 2, 1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0);
    expect_out("s2.indep", 0, 0, 0, 0);
    next_cycle();
    drive(1'b1, 3, 5, 1'b1, 1'b1, 10, 1'b1, 1'b0, 1'b0);
    expect_out("s2.stall", 1, 0, 0, 0);
    next_cycle();
    expect_out("s2.issue", 0, 0, 0, 1);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();

    // xori r7 then user of r7: non-load writer, no stall.
    drive(1'b1, 2, 7, 1'b1, 1'b0, 7, 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 7, 7, 1'b1, 1'b1, 11, 1'b1, 1'b0, 1'b0);
    expect_out("s3.xori_use", 0, 0, 0, 0);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();

    // Back-to-back loads r5, r6; consumer of both sees the union.
    lw(5);
    next_cycle();
    lw(6);
    expect_out("bb.lw6", 0, 0, 0, 0);
    next_cycle();
    drive(1'b1, 5, 6, 1'b1, 1'b1, 12, 1'b1, 1'b0, 1'b0);
    expect_out("bb.union1", 1, 0, 0, 0);
    next_cycle();
    expect_out("bb.union2", 1, 0, 0, 1);
    next_cycle();
    expect_out("bb.issue", 0, 0, 0, 1);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();

    // Freeze for 3 cycles after the first stall cycle.
    lw(5);
    next_cycle();
    drive(1'b1, 5, 0, 1'b1, 1'b0, 13, 1'b1, 1'b0, 1'b0);
    expect_out("fz.stall1", 1, 0, 0, 0);
    next_cycle();
    mem_busy = 1'b1;
    expect_out("fz.f1", 0, 0, 1, 1);
    next_cycle();
    expect_out("fz.f2", 0, 0, 1, 2);
    next_cycle();
    expect_out("fz.f3", 0, 0, 1, 2);
    next_cycle();
    mem_busy = 1'b0;
    expect_out("fz.stall2", 1, 0, 0, 2);
    next_cycle();
    expect_out("fz.issue", 0, 0, 0, 1);
    next_cycle();
    idle();
    expect_out("fz.run", 0, 0, 0, 0);
    next_cycle();
    next_cycle();

    // Reset pulse in the middle of a load-use stall.
    lw(5);
    next_cycle();
    drive(1'b1, 5, 0, 1'b1, 1'b0, 14, 1'b1, 1'b0, 1'b1);
    expect_out("rs.stall", 1, 0, 0, 0);
    #2;
    rst_n    = 1'b0;
    mem_busy = 1'b1;
    #1;
    chk("rs.now.stall",  int'(stall),  0);
    chk("rs.now.bubble", int'(bubble), 0);
    chk("rs.now.flush",  int'(flush),  0);
    chk("rs.now.freeze", int'(freeze), 0);
    chk("rs.now.state",  int'(state),  0);
    @(posedge clk);
    #1;
    mem_busy = 1'b0;
    rst_n    = 1'b1;
    drive(1'b1, 5, 0, 1'b1, 1'b0, 14, 1'b1, 1'b0, 1'b0);
    expect_out("rs.after1", 0, 0, 0, 0);
    next_cycle();
    idle();
    expect_out("rs.after2", 0, 0, 0, 0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
